// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// bundled stall/flush control word routed to the datapath stage registers.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_NONE = '0;

  localparam hz_ctrl_t HZ_BOOT = '{
    pc_stall: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0
  };

  // Freeze everything up to MEM and drain a bubble into WB.
  localparam hz_ctrl_t HZ_MEM_HOLD = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, ex_mem_stall: 1'b1,
    mem_wb_flush: 1'b1, default: 1'b0
  };

  localparam hz_ctrl_t HZ_REDIRECT = '{
    if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0
  };

  localparam hz_ctrl_t HZ_LOADUSE = '{
    pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1, default: 1'b0
  };

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependency).
module hazard_loaduse_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  loaduse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign loaduse = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline: boot hold,
// load-use stalls, redirect flushes, dmem wait states with timeout, perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  mem_fault,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_reg;
  hz_state_t         state_next;
  logic [BOOT_W-1:0] boot_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              mem_fault_reg;
  hz_ctrl_t          ctrl;
  logic              loaduse;
  logic              memwait;
  logic              wait_expired;
  logic              redirect_taken;
  logic [1:0]        perf_inc;
  logic [CNT_W-1:0]  perf_cnt [2];

  hazard_loaduse_detect u_loaduse (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .loaduse     (loaduse)
  );

  assign memwait      = mem_req && !dmem_ready;
  assign wait_expired = memwait && (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT: begin
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (memwait) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!memwait) begin
          state_next = RUN;
        end else if (wait_expired) begin
          state_next = FAULT;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    ctrl           = HZ_NONE;
    redirect_taken = 1'b0;
    case (state_reg)
      BOOT: ctrl = HZ_BOOT;
      RUN, MEM_WAIT: begin
        // A redirect also wins over load-use: the ID instruction is wrong-path.
        if (memwait) begin
          ctrl = HZ_MEM_HOLD;
        end else if (ex_redirect) begin
          ctrl           = HZ_REDIRECT;
          redirect_taken = 1'b1;
        end else if (loaduse) begin
          ctrl = HZ_LOADUSE;
        end
      end
      FAULT:   ctrl = HZ_MEM_HOLD;
      default: ctrl = HZ_NONE;
    endcase
  end

  // The wait counter includes the RUN cycle that first saw memwait, so a fault
  // lands exactly MEM_TIMEOUT edges after the wait began.
  always_ff @(posedge clk) begin
    if (reset) begin
      boot_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      mem_fault_reg <= 1'b0;
    end else begin
      if (state_reg == BOOT && boot_cnt_reg != BOOT_LAST) begin
        boot_cnt_reg <= boot_cnt_reg + BOOT_W'(1);
      end
      if (state_next == MEM_WAIT) begin
        if (state_reg == RUN) begin
          wait_cnt_reg <= WAIT_W'(1);
        end else begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end
      end else begin
        wait_cnt_reg <= '0;
      end
      if (state_next == FAULT) begin
        mem_fault_reg <= 1'b1;
      end
    end
  end

  assign perf_inc[0] = ctrl.pc_stall && (state_reg == RUN || state_reg == MEM_WAIT);
  assign perf_inc[1] = redirect_taken;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi] && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign perf_cnt[gi] = cnt_reg;
    end
  endgenerate

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_fault    = mem_fault_reg;
  assign stall_cnt    = perf_cnt[0];
  assign flush_cnt    = perf_cnt[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-level reference model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_pipeline_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             mem_req, dmem_ready;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_fault;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .mem_fault    (mem_fault),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: cycles of boot left, length of the current memwait streak,
  // a sticky fault flag and two saturating counters.
  bit m_valid = 1'b0;
  int m_boot_left, m_streak, m_stall, m_flush;
  bit m_faulted;

  // Control word order: pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, mem_wb flushes.
  function automatic logic [6:0] model_ctrl();
    bit mw;
    bit lu;
    mw = mem_req && !dmem_ready;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (m_boot_left > 0) return 7'b1000110;
    if (m_faulted)       return 7'b1111001;
    if (mw)              return 7'b1111001;
    if (ex_redirect)     return 7'b0000110;
    if (lu)              return 7'b1100010;
    return 7'b0000000;
  endfunction

  always @(posedge clk) begin : model_upd
    logic [6:0] c;
    bit mw;
    c  = model_ctrl();
    mw = mem_req && !dmem_ready;
    if (reset) begin
      m_valid     <= 1'b1;
      m_boot_left <= BOOT_CYCLES;
      m_streak    <= 0;
      m_faulted   <= 1'b0;
      m_stall     <= 0;
      m_flush     <= 0;
    end else if (m_valid) begin
      if (m_boot_left > 0) begin
        m_boot_left <= m_boot_left - 1;
      end else if (!m_faulted) begin
        if (c[6] && m_stall < CNT_MAX) m_stall <= m_stall + 1;
        if (!mw && ex_redirect && m_flush < CNT_MAX) m_flush <= m_flush + 1;
        if (mw) begin
          m_streak <= m_streak + 1;
          if (m_streak + 1 >= MEM_TIMEOUT) m_faulted <= 1'b1;
        end else begin
          m_streak <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    $display("vector %-22s got %0h want %0h", name, act, exp);
    check(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("ctrl", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_flush, id_ex_flush, mem_wb_flush}, model_ctrl());
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
      check("mem_fault", mem_fault, m_faulted);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    ex_redirect = 0; mem_req = 0; dmem_ready = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cyc();
    reset = 0;
    for (int i = 0; i < BOOT_CYCLES; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    cyc();
    reset = 0;
    // Boot hold
    @(negedge clk);
    lit("boot0_pc_stall", pc_stall, 1);
    lit("boot0_id_ex_flush", id_ex_flush, 1);
    lit("boot0_stall_cnt", stall_cnt, 0);
    lit("boot0_mem_fault", mem_fault, 0);
    cyc();
    @(negedge clk); lit("boot1_pc_stall", pc_stall, 1);
    cyc();
    @(negedge clk); lit("run_pc_stall", pc_stall, 0);
    cyc();

    // Load-use on rs2
    set_loaduse(5'd5);
    @(negedge clk);
    lit("lu_pc_stall", pc_stall, 1);
    lit("lu_if_id_stall", if_id_stall, 1);
    lit("lu_id_ex_flush", id_ex_flush, 1);
    cyc();
    clear_inputs();
    @(negedge clk);
    lit("lu_end_pc_stall", pc_stall, 0);
    lit("lu_stall_cnt", stall_cnt, 1);
    cyc();
    set_loaduse(5'd0);
    @(negedge clk); lit("lu_x0_pc_stall", pc_stall, 0);
    cyc();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 0;
    @(negedge clk); lit("lu_unused_rs1", pc_stall, 0);
    cyc();
    ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1;
    @(negedge clk); lit("lu_rs1_pc_stall", pc_stall, 1);
    cyc();
    clear_inputs();
    @(negedge clk); lit("lu_x0_stall_cnt", stall_cnt, 2);
    cyc();

    // Redirect beats load-use; memwait beats redirect
    do_reset();
    set_loaduse(5'd9);
    ex_redirect = 1;
    @(negedge clk);
    lit("rd_if_id_flush", if_id_flush, 1);
    lit("rd_id_ex_flush", id_ex_flush, 1);
    lit("rd_pc_stall", pc_stall, 0);
    cyc();
    clear_inputs();
    @(negedge clk);
    lit("rd_flush_cnt", flush_cnt, 1);
    lit("rd_stall_cnt", stall_cnt, 0);
    cyc();
    mem_req = 1; dmem_ready = 0; ex_redirect = 1;
    @(negedge clk);
    lit("mw_rd_ex_mem_stall", ex_mem_stall, 1);
    lit("mw_rd_if_id_flush", if_id_flush, 0);
    cyc();
    clear_inputs();
    @(negedge clk); lit("mw_rd_flush_cnt", flush_cnt, 1);
    cyc();

    // Dmem wait of 3 cycles; ready lands on the timeout compare cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; dmem_ready = 0;
      @(negedge clk);
      lit($sformatf("dw%0d_mem_wb_flush", i), mem_wb_flush, 1);
      cyc();
    end
    dmem_ready = 1;
    @(negedge clk);
    lit("dw_ready_pc_stall", pc_stall, 0);
    lit("dw_ready_mem_wb_flush", mem_wb_flush, 0);
    cyc();
    clear_inputs();
    @(negedge clk);
    lit("dw_stall_cnt", stall_cnt, 3);
    lit("dw_no_fault", mem_fault, 0);
    cyc();

    // Wait ended by mem_req dropping
    for (int i = 0; i < 2; i++) begin
      mem_req = 1; dmem_ready = 0;
      @(negedge clk);
      cyc();
    end
    mem_req = 0;
    @(negedge clk);
    lit("drop_pc_stall", pc_stall, 0);
    lit("drop_stall_cnt", stall_cnt, 5);
    cyc();

    // Timeout to FAULT, then reset out of it
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_req = 1; dmem_ready = 0;
      @(negedge clk);
      if (i == 3) lit("to_before_fault", mem_fault, 0);
      if (i == 4) lit("to_fault_set", mem_fault, 1);
      cyc();
    end
    clear_inputs();
    @(negedge clk);
    lit("to_fault_sticky", mem_fault, 1);
    lit("to_fault_pc_stall", pc_stall, 1);
    lit("to_fault_ex_mem_stall", ex_mem_stall, 1);
    lit("to_stall_cnt", stall_cnt, 4);
    cyc();
    reset = 1;
    @(negedge clk);
    cyc();
    reset = 0;
    @(negedge clk);
    lit("to_reset_fault", mem_fault, 0);
    lit("to_reset_boot_stall", pc_stall, 1);
    lit("to_reset_stall_cnt", stall_cnt, 0);
    cyc();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_loaduse(5'd3);
      @(negedge clk);
      cyc();
    end
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      ex_redirect = 1;
      @(negedge clk);
      cyc();
    end
    clear_inputs();
    @(negedge clk);
    lit("sat_stall_cnt", stall_cnt, 7);
    lit("sat_flush_cnt", flush_cnt, 7);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
